ifm_filter_load_sched: RTL
==========================

Name: ifm_filter_load_sched

Overview:
Load scheduler between the CNN controller and the single DRAM read port. It accepts one-shot filter-load requests (frame start) and IFM row-load requests (req_load/req_row pulses from the controller). It arbitrates them onto one burst read master, computes burst address and length, and steers returned beats into the IFM row ring or the filter buffer. It returns the done handshakes that the controller waits on in VSYNC and HSYNC.

Parameters:
W_SIZE, 12, width/height/row field width
W_CHANNEL, 12, tiled channel count width
W_ADDR, 32, byte address width
W_BEATS, 16, burst length / beat index width
W_DATA, 64, beat data width
BEAT_BYTES, 8, bytes per beat (power of two)

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
q_ifm_base  in  W_ADDR  IFM frame base address
q_filter_base  in  W_ADDR  filter base address
q_width  in  W_SIZE  columns per row
q_channel  in  W_CHANNEL  tiled input channels
q_filter_beats  in  W_BEATS  filter load length in beats
q_start  in  1  pulse: load filters for a new frame
i_ifm_req_load  in  1  pulse: load IFM row
i_ifm_req_row  in  W_SIZE  row index, valid with req_load
o_ifm_buf_done  out  1  1-cycle pulse: row load complete
o_filter_buf_done  out  1  level: filters resident
o_rd_req  out  1  burst request
o_rd_addr  out  W_ADDR  burst byte address
o_rd_len  out  W_BEATS  burst length in beats (>=1)
i_rd_ack  in  1  burst accepted
i_rd_valid  in  1  read beat valid
i_rd_data  in  W_DATA  read beat
o_buf_we  out  1  buffer write strobe
o_buf_sel  out  1  0 = IFM ring, 1 = filter buffer
o_buf_slot  out  2  IFM ring slot = row[1:0]; 0 for filter
o_buf_waddr  out  W_BEATS  beat index within the burst
o_buf_wdata  out  W_DATA  registered copy of i_rd_data
o_busy  out  1  state != IDLE or a request is pending
o_err_overrun  out  1  sticky: request dropped

Behaviour:
- All state changes on the clk rising edge. rstn low clears state to IDLE, clears pending flags, counters, o_err_overrun, o_filter_buf_done, and all outputs to 0. Reset mid-burst abandons the burst. Beats arriving after reset are ignored until a new ack.
- Pending latches:
  - q_start sets filt_pend and clears o_filter_buf_done.
  - i_ifm_req_load sets ifm_pend and captures ifm_row.
  - A request that arrives while its own pend flag is set, or while its own burst is in flight, is dropped and sets o_err_overrun. The original request is unaffected.
- Row beats: row_beats = q_width * q_channel, truncated to W_BEATS.
- IFM address: q_ifm_base + ifm_row*row_beats*BEAT_BYTES, computed modulo 2^W_ADDR.
- Filter address: q_filter_base; length q_filter_beats.
- FSM states IDLE, REQ, XFER, DONE.
  - IDLE: if filt_pend, select filter (filter has fixed priority); else if ifm_pend, select IFM. Clear the selected pend flag and register addr, len and sel.
    - Zero length goes straight to DONE, with no bus request.
    - Nonzero length goes to REQ.
  - REQ: o_rd_req=1 with stable addr/len until i_rd_ack is sampled high, then XFER. o_rd_req drops in the cycle after the ack.
  - XFER: each i_rd_valid produces o_buf_we one cycle later, with waddr = beat counter and data registered. The beat counter increments per valid. On the valid with counter == len-1, go to DONE. i_rd_valid outside XFER is ignored.
  - DONE (1 cycle):
    - IFM: o_ifm_buf_done pulses high for exactly this cycle.
    - Filter: o_filter_buf_done rises and holds until the next q_start or reset.
    - Then IDLE.
- Latency: the last beat at cycle t gives o_buf_we at t+1 and done at t+1 (same cycle as the final write).
- Minimum idle-to-request latency is 1 cycle after the pend flag is set.
- A request arriving in the same cycle as DONE is latched and serviced from the following IDLE.
- Simultaneous q_start and i_ifm_req_load: both latched, filter serviced first.

Decomposition:
- Shared package controller_params.vh: W_SIZE, W_CHANNEL, W_ADDR, W_BEATS, W_DATA, BEAT_BYTES; state encodings ST_LS_IDLE/REQ/XFER/DONE; BUF_SEL_IFM=0, BUF_SEL_FILTER=1.
- One natural sub-module, load_addr_gen: registered multiply-add computing the IFM address and row_beats from the captured row. It runs during IDLE→REQ, so a 1-cycle register stage is allowed if REQ waits one extra cycle.

Test Plan:
- Filter load: base 0x1000, beats 4, q_start, ack after 2 cycles, 4 valid beats → o_rd_addr 0x1000, len 4; waddr 0..3, sel 1; o_filter_buf_done rises after beat 4 and stays high.
- IFM row: width 3, channel 2, base 0x8000, row 5, BEAT_BYTES 8 → addr 0x8000 + 5*6*8 = 0x80F0, len 6, slot 1, single done pulse.
- Simultaneous q_start and req_load(row 0) → filter burst first, then IFM burst addr = q_ifm_base; exactly one o_ifm_buf_done.
- Second req_load during an IFM burst → o_err_overrun=1; only one burst and one done.
- Zero length (q_filter_beats=0) → no o_rd_req; o_filter_buf_done high 2 cycles after q_start.
- rstn low mid-XFER after 2 of 6 beats → all outputs 0, IDLE. Stray valids produce no writes. A new req_load completes normally.

Source files
------------

// File: rtl/ifm_filter_load_sched_pkg.sv
// Shared widths, FSM encoding and address arithmetic for the IFM/filter load scheduler.
package ifm_filter_load_sched_pkg;

  localparam int W_SIZE     = 12;
  localparam int W_CHANNEL  = 12;
  localparam int W_ADDR     = 32;
  localparam int W_BEATS    = 16;
  localparam int W_DATA     = 64;
  localparam int BEAT_BYTES = 8;
  localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);

  typedef enum logic [1:0] {
    ST_LS_IDLE = 2'd0,
    ST_LS_REQ  = 2'd1,
    ST_LS_XFER = 2'd2,
    ST_LS_DONE = 2'd3
  } ls_state_e;

  localparam logic BUF_SEL_IFM    = 1'b0;
  localparam logic BUF_SEL_FILTER = 1'b1;

  // Beats per IFM row, deliberately truncated to the burst-length width.
  function automatic logic [W_BEATS-1:0] calc_row_beats(
    input logic [W_SIZE-1:0]    width,
    input logic [W_CHANNEL-1:0] channel
  );
    logic [W_SIZE+W_CHANNEL-1:0] prod;
    prod = (W_SIZE+W_CHANNEL)'(width) * (W_SIZE+W_CHANNEL)'(channel);
    return prod[W_BEATS-1:0];
  endfunction

  function automatic logic [W_ADDR-1:0] calc_row_addr(
    input logic [W_ADDR-1:0]  base,
    input logic [W_SIZE-1:0]  row,
    input logic [W_BEATS-1:0] row_beats
  );
    logic [W_ADDR-1:0] beat_off;
    beat_off = W_ADDR'(row) * W_ADDR'(row_beats);
    return base + (beat_off << BEAT_SHIFT);
  endfunction

endpackage

// File: rtl/ifm_filter_load_sched_load_addr_gen.sv
// Registered multiply-add producing the IFM row burst address and length.
// Fed with the next-cycle row value so its output lines up with the captured row register.
module load_addr_gen
  import ifm_filter_load_sched_pkg::*;
(
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [W_ADDR-1:0]    ifm_base_i,
  input  logic [W_SIZE-1:0]    width_i,
  input  logic [W_CHANNEL-1:0] channel_i,
  input  logic [W_SIZE-1:0]    row_i,
  output logic [W_ADDR-1:0]    addr_o,
  output logic [W_BEATS-1:0]   row_beats_o
);

  logic [W_BEATS-1:0] row_beats_d, row_beats_q;
  logic [W_ADDR-1:0]  addr_d, addr_q;

  always_comb begin
    row_beats_d = calc_row_beats(width_i, channel_i);
    addr_d      = calc_row_addr(ifm_base_i, row_i, row_beats_d);
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values, whatever the statement order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      row_beats_q <= '0;
      addr_q      <= '0;
    end else begin
      row_beats_q <= row_beats_d;
      addr_q      <= addr_d;
    end
  end

  assign addr_o      = addr_q;
  assign row_beats_o = row_beats_q;

endmodule

// File: rtl/ifm_filter_load_sched.sv
// Arbitrates filter and IFM row loads onto one DRAM burst read master and
// steers returned beats into the IFM ring or filter buffer.
module ifm_filter_load_sched
  import ifm_filter_load_sched_pkg::*;
(
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [W_ADDR-1:0]    q_ifm_base,
  input  logic [W_ADDR-1:0]    q_filter_base,
  input  logic [W_SIZE-1:0]    q_width,
  input  logic [W_CHANNEL-1:0] q_channel,
  input  logic [W_BEATS-1:0]   q_filter_beats,
  input  logic                 q_start,
  input  logic                 i_ifm_req_load,
  input  logic [W_SIZE-1:0]    i_ifm_req_row,
  output logic                 o_ifm_buf_done,
  output logic                 o_filter_buf_done,
  output logic                 o_rd_req,
  output logic [W_ADDR-1:0]    o_rd_addr,
  output logic [W_BEATS-1:0]   o_rd_len,
  input  logic                 i_rd_ack,
  input  logic                 i_rd_valid,
  input  logic [W_DATA-1:0]    i_rd_data,
  output logic                 o_buf_we,
  output logic                 o_buf_sel,
  output logic [1:0]           o_buf_slot,
  output logic [W_BEATS-1:0]   o_buf_waddr,
  output logic [W_DATA-1:0]    o_buf_wdata,
  output logic                 o_busy,
  output logic                 o_err_overrun
);

  ls_state_e          state_q;
  logic               filt_pend_q, filt_pend_d;
  logic               ifm_pend_q, ifm_pend_d;
  logic [W_SIZE-1:0]  ifm_row_q, ifm_row_d;
  logic [W_BEATS-1:0] beat_cnt_q;
  logic               sel_q;
  logic [1:0]         slot_q;

  logic               in_burst, filt_accept, filt_drop, ifm_accept, ifm_drop;
  logic               take_filt, take_ifm;
  logic [W_ADDR-1:0]  gen_addr;
  logic [W_BEATS-1:0] gen_row_beats;

  load_addr_gen u_addr_gen (
    .clk         (clk),
    .rstn        (rstn),
    .ifm_base_i  (q_ifm_base),
    .width_i     (q_width),
    .channel_i   (q_channel),
    .row_i       (ifm_row_d),
    .addr_o      (gen_addr),
    .row_beats_o (gen_row_beats)
  );

  // A request collides only with its own pending flag or its own burst on the bus.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    in_burst    = (state_q == ST_LS_REQ) || (state_q == ST_LS_XFER);
    filt_accept = q_start && !filt_pend_q && !(in_burst && sel_q == BUF_SEL_FILTER);
    filt_drop   = q_start && !filt_accept;
    ifm_accept  = i_ifm_req_load && !ifm_pend_q && !(in_burst && sel_q == BUF_SEL_IFM);
    ifm_drop    = i_ifm_req_load && !ifm_accept;
    take_filt   = (state_q == ST_LS_IDLE) && filt_pend_q;
    take_ifm    = (state_q == ST_LS_IDLE) && !filt_pend_q && ifm_pend_q;

    filt_pend_d = filt_pend_q;
    if (take_filt)   filt_pend_d = 1'b0;
    if (filt_accept) filt_pend_d = 1'b1;

    ifm_pend_d = ifm_pend_q;
    if (take_ifm)   ifm_pend_d = 1'b0;
    if (ifm_accept) ifm_pend_d = 1'b1;

    ifm_row_d = ifm_accept ? i_ifm_req_row : ifm_row_q;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q           <= ST_LS_IDLE;
      filt_pend_q       <= 1'b0;
      ifm_pend_q        <= 1'b0;
      ifm_row_q         <= '0;
      beat_cnt_q        <= '0;
      sel_q             <= BUF_SEL_IFM;
      slot_q            <= '0;
      o_rd_req          <= 1'b0;
      o_rd_addr         <= '0;
      o_rd_len          <= '0;
      o_buf_we          <= 1'b0;
      o_buf_waddr       <= '0;
      o_buf_wdata       <= '0;
      o_ifm_buf_done    <= 1'b0;
      o_filter_buf_done <= 1'b0;
      o_err_overrun     <= 1'b0;
    end else begin
      filt_pend_q    <= filt_pend_d;
      ifm_pend_q     <= ifm_pend_d;
      ifm_row_q      <= ifm_row_d;
      o_buf_we       <= 1'b0;
      o_ifm_buf_done <= 1'b0;
      if (filt_drop || ifm_drop) o_err_overrun <= 1'b1;

      case (state_q)
        ST_LS_IDLE: begin
          beat_cnt_q <= '0;
          if (take_filt) begin
            sel_q     <= BUF_SEL_FILTER;
            slot_q    <= 2'd0;
            o_rd_addr <= q_filter_base;
            o_rd_len  <= q_filter_beats;
            if (q_filter_beats == '0) begin
              state_q           <= ST_LS_DONE;
              o_filter_buf_done <= 1'b1;
            end else begin
              state_q  <= ST_LS_REQ;
              o_rd_req <= 1'b1;
            end
          end else if (take_ifm) begin
            sel_q     <= BUF_SEL_IFM;
            slot_q    <= ifm_row_q[1:0];
            o_rd_addr <= gen_addr;
            o_rd_len  <= gen_row_beats;
            if (gen_row_beats == '0) begin
              state_q        <= ST_LS_DONE;
              o_ifm_buf_done <= 1'b1;
            end else begin
              state_q  <= ST_LS_REQ;
              o_rd_req <= 1'b1;
            end
          end
        end
        ST_LS_REQ: begin
          if (i_rd_ack) begin
            o_rd_req <= 1'b0;
            state_q  <= ST_LS_XFER;
          end
        end
        ST_LS_XFER: begin
          if (i_rd_valid) begin
            o_buf_we    <= 1'b1;
            o_buf_waddr <= beat_cnt_q;
            o_buf_wdata <= i_rd_data;
            beat_cnt_q  <= beat_cnt_q + 1'b1;
            // Done flags rise together with the final write strobe.
            if (beat_cnt_q == o_rd_len - 1'b1) begin
              state_q <= ST_LS_DONE;
              if (sel_q == BUF_SEL_IFM) o_ifm_buf_done    <= 1'b1;
              else                      o_filter_buf_done <= 1'b1;
            end
          end
        end
        ST_LS_DONE: state_q <= ST_LS_IDLE;
        default:    state_q <= ST_LS_IDLE;
      endcase

      // A newly accepted frame start invalidates resident filters, even against a same-cycle completion.
      if (filt_accept) o_filter_buf_done <= 1'b0;
    end
  end

  assign o_buf_sel  = sel_q;
  assign o_buf_slot = slot_q;
  assign o_busy     = (state_q != ST_LS_IDLE) || filt_pend_q || ifm_pend_q;

endmodule
